// File: rtl/usonic_echo_detector.sv
// Ultrasonic time-of-flight echo detector: blanks the transmitter ring-down, finds the first
// threshold crossing after burst_start, then tracks the echo peak for peak_len samples.
`timescale 1ns/1ps
module usonic_echo_detector #(
    parameter int unsigned dbits    = 16,
    parameter int unsigned sbits    = 16,
    parameter int unsigned peak_len = 8
) (
    input  logic             SYS_CLK,
    input  logic             reset,
    input  logic             burst_start,
    input  logic             sample_valid,
    input  logic [dbits-1:0] sample,
    input  logic [dbits-1:0] threshold,
    input  logic [sbits-1:0] blank_samples,
    input  logic [sbits-1:0] window_samples,
    output logic             tof_valid,
    output logic             timeout,
    output logic [sbits-1:0] tof,
    output logic [dbits-1:0] peak,
    output logic [sbits-1:0] peak_idx,
    output logic             busy
);

    localparam int unsigned HBITS = (peak_len < 2) ? 1 : $clog2(peak_len);
    localparam logic [HBITS-1:0] HOLD_LAST = HBITS'(peak_len - 1);
    localparam logic [sbits-1:0] IDX_MAX = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] SEARCH = 2'd2;
    localparam logic [1:0] PEAK   = 2'd3;

    logic [1:0]       state, state_d;
    logic [sbits-1:0] blank_q, blank_d, window_q, window_d;
    logic [sbits-1:0] idx_q, idx_d;
    logic [HBITS-1:0] hold_q, hold_d;
    logic [sbits-1:0] w_tof_q, w_tof_d, w_pidx_q, w_pidx_d;
    logic [dbits-1:0] w_peak_q, w_peak_d;
    logic             tof_valid_d, timeout_d;
    logic [sbits-1:0] tof_d, peak_idx_d;
    logic [dbits-1:0] peak_d;

    logic [sbits-1:0] idx_inc;
    logic [HBITS-1:0] hold_inc;
    logic             win_hit, bigger;
    logic [dbits-1:0] pk_n;
    logic [sbits-1:0] pidx_n;

    assign busy = (state != IDLE);

    // Next-state and datapath decode; burst_start has priority over any strobe
    always_comb begin
        state_d     = state;
        blank_d     = blank_q;
        window_d    = window_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        w_tof_d     = w_tof_q;
        w_peak_d    = w_peak_q;
        w_pidx_d    = w_pidx_q;
        tof_valid_d = 1'b0;
        timeout_d   = 1'b0;
        tof_d       = tof;
        peak_d      = peak;
        peak_idx_d  = peak_idx;

        idx_inc  = (idx_q == IDX_MAX) ? idx_q : idx_q + sbits'(1);
        hold_inc = hold_q + HBITS'(1);
        // idx+1 >= window also covers window <= blank: first missed SEARCH sample times out
        win_hit  = ((sbits+1)'(idx_q) + (sbits+1)'(1)) >= (sbits+1)'(window_q);
        bigger   = sample > w_peak_q;
        pk_n     = bigger ? sample : w_peak_q;
        pidx_n   = bigger ? idx_q : w_pidx_q;

        if (burst_start) begin
            blank_d  = blank_samples;
            window_d = window_samples;
            idx_d    = '0;
            hold_d   = '0;
            state_d  = (blank_samples == '0) ? SEARCH : BLANK;
        end else if (sample_valid) begin
            case (state)
                BLANK: begin
                    idx_d = idx_inc;
                    if (idx_q == blank_q - sbits'(1)) state_d = SEARCH;
                end
                SEARCH: begin
                    if (sample >= threshold) begin
                        w_tof_d  = idx_q;
                        w_peak_d = sample;
                        w_pidx_d = idx_q;
                        idx_d    = idx_inc;
                        hold_d   = '0;
                        if (HOLD_LAST == '0) begin
                            tof_valid_d = 1'b1;
                            tof_d       = idx_q;
                            peak_d      = sample;
                            peak_idx_d  = idx_q;
                            state_d     = IDLE;
                        end else begin
                            state_d = PEAK;
                        end
                    end else if (win_hit) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
                PEAK: begin
                    idx_d    = idx_inc;
                    hold_d   = hold_inc;
                    w_peak_d = pk_n;
                    w_pidx_d = pidx_n;
                    if (hold_inc == HOLD_LAST) begin
                        tof_valid_d = 1'b1;
                        tof_d       = w_tof_q;
                        peak_d      = pk_n;
                        peak_idx_d  = pidx_n;
                        state_d     = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            state     <= IDLE;
            blank_q   <= '0;
            window_q  <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            w_tof_q   <= '0;
            w_peak_q  <= '0;
            w_pidx_q  <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
            tof       <= '0;
            peak      <= '0;
            peak_idx  <= '0;
        end else begin
            state     <= state_d;
            blank_q   <= blank_d;
            window_q  <= window_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            w_tof_q   <= w_tof_d;
            w_peak_q  <= w_peak_d;
            w_pidx_q  <= w_pidx_d;
            tof_valid <= tof_valid_d;
            timeout   <= timeout_d;
            tof       <= tof_d;
            peak      <= peak_d;
            peak_idx  <= peak_idx_d;
        end
    end

endmodule

// File: tb/tb_usonic_echo_detector.sv
// Bench for usonic_echo_detector: directed bursts plus random bursts checked cycle by cycle
// against a per-burst reference computed from the sample list.
`timescale 1ns/1ps
module tb_usonic_echo_detector;

    localparam int PEAK_LEN = 8;

    logic        SYS_CLK = 1'b0;
    logic        reset;
    logic        burst_start;
    logic        sample_valid;
    logic [15:0] sample;
    logic [15:0] threshold;
    logic [15:0] blank_samples;
    logic [15:0] window_samples;
    logic        tof_valid;
    logic        timeout;
    logic [15:0] tof;
    logic [15:0] peak;
    logic [15:0] peak_idx;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_busy = 0;
    int last_tof = 0, last_pk = 0, last_pidx = 0;
    int e_tof = 0, e_pk = 0, e_pidx = 0;

    usonic_echo_detector #(.dbits(16), .sbits(16), .peak_len(PEAK_LEN)) dut (
        .SYS_CLK       (SYS_CLK),
        .reset         (reset),
        .burst_start   (burst_start),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .threshold     (threshold),
        .blank_samples (blank_samples),
        .window_samples(window_samples),
        .tof_valid     (tof_valid),
        .timeout       (timeout),
        .tof           (tof),
        .peak          (peak),
        .peak_idx      (peak_idx),
        .busy          (busy)
    );

    always #12.5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Burst outcome from the sample list: kind 0 none, 1 result, 2 timeout; dec = deciding index
    function automatic void model(input int blank, input int window, input int thr, input int s[$],
                                  output int kind, output int t, output int pk, output int pi,
                                  output int dec);
        bit crossed = 0;
        int cnt = 0;
        kind = 0; t = 0; pk = 0; pi = 0; dec = -1;
        for (int i = 0; i < s.size(); i++) begin
            if (kind != 0) break;
            if (i < blank) continue;
            if (!crossed) begin
                if (s[i] >= thr) begin
                    crossed = 1; t = i; pk = s[i]; pi = i; cnt = 1;
                end else if (i + 1 >= window) begin
                    kind = 2; dec = i;
                end
            end else begin
                cnt++;
                if (s[i] > pk) begin pk = s[i]; pi = i; end
            end
            if (crossed && kind == 0 && cnt == PEAK_LEN) begin kind = 1; dec = i; end
        end
    endfunction

    // One clock of stimulus followed by a full check of the outputs it produced
    task automatic step(input bit bs, input bit sv, input int sd, input int kind);
        burst_start  = bs;
        sample_valid = sv;
        sample       = 16'(sd);
        @(negedge SYS_CLK);
        if (kind == 1) begin last_tof = e_tof; last_pk = e_pk; last_pidx = e_pidx; end
        if (kind != 0) exp_busy = 0;
        if (bs) exp_busy = 1;
        check("tof_valid", int'(tof_valid), (kind == 1) ? 1 : 0);
        check("timeout", int'(timeout), (kind == 2) ? 1 : 0);
        check("busy", int'(busy), exp_busy);
        check("tof", int'(tof), last_tof);
        check("peak", int'(peak), last_pk);
        check("peak_idx", int'(peak_idx), last_pidx);
        burst_start  = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic run_burst(input int blank, input int window, input int thr, input int q[$],
                             input int nsend, input bit coinc, input int maxgap);
        int qs[$];
        int kind, dec;
        for (int i = 0; i < nsend && i < q.size(); i++) qs.push_back(q[i]);
        model(blank, window, thr, qs, kind, e_tof, e_pk, e_pidx, dec);
        blank_samples  = 16'(blank);
        window_samples = 16'(window);
        threshold      = 16'(thr);
        step(1'b1, coinc, int'($urandom_range(0, 16'hFFFF)), 0);
        for (int i = 0; i < qs.size(); i++) begin
            repeat (int'($urandom_range(0, maxgap))) step(1'b0, 1'b0, 0, 0);
            step(1'b0, 1'b1, qs[i], (i == dec) ? kind : 0);
        end
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        burst_start  = 1'b0;
        sample_valid = 1'b0;
        @(negedge SYS_CLK);
        exp_busy = 0; last_tof = 0; last_pk = 0; last_pidx = 0;
        check("rst_tof_valid", int'(tof_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tof", int'(tof), 0);
        check("rst_peak", int'(peak), 0);
        check("rst_peak_idx", int'(peak_idx), 0);
        reset = 1'b0;
    endtask

    initial begin
        int q[$];
        reset = 1'b1; burst_start = 1'b0; sample_valid = 1'b0; sample = '0;
        threshold = '0; blank_samples = '0; window_samples = '0;
        repeat (3) @(negedge SYS_CLK);
        do_reset();

        // Ramp: crossing at index 8, peak at index 15
        q.delete();
        for (int i = 0; i < 30; i++) q.push_back(i * 16'h0100);
        run_burst(4, 100, 16'h0800, q, 30, 1'b0, 1);
        check("t1_tof", int'(tof), 8);
        check("t1_peak", int'(peak), 16'h0F00);
        check("t1_peak_idx", int'(peak_idx), 15);

        // Flat below threshold: timeout after index 19, result held
        q.delete();
        for (int i = 0; i < 30; i++) q.push_back(16'h0100);
        run_burst(4, 20, 16'h0800, q, 30, 1'b0, 2);
        check("t2_tof_held", int'(tof), 8);

        // Abort at index 6, then a fresh burst hitting at index 3
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back((i == 10) ? 16'h0900 : 0);
        run_burst(2, 100, 16'h0800, q, 7, 1'b0, 1);
        q.delete();
        for (int i = 0; i < 15; i++) q.push_back((i == 3) ? 16'h0900 : 0);
        run_burst(0, 100, 16'h0800, q, 15, 1'b0, 1);
        check("t4_tof", int'(tof), 3);

        // Coincident burst_start/sample_valid: that sample is discarded
        q.delete();
        q.push_back(16'hFFFF);
        for (int i = 0; i < 10; i++) q.push_back(0);
        run_burst(0, 100, 16'h0800, q, 11, 1'b1, 0);
        check("t5_tof", int'(tof), 0);
        check("t5_peak", int'(peak), 16'hFFFF);

        // Tie in the peak phase keeps the earliest index
        q.delete();
        for (int i = 0; i < 20; i++)
            q.push_back((i == 10) ? 16'h0900 : (i == 12 || i == 14) ? 16'h0C00 : 0);
        run_burst(0, 100, 16'h0800, q, 20, 1'b0, 1);
        check("t3_tof", int'(tof), 10);
        check("t3_peak", int'(peak), 16'h0C00);
        check("t3_peak_idx", int'(peak_idx), 12);

        // Reset mid-PEAK, then a normal burst
        q.delete();
        for (int i = 0; i < 30; i++) q.push_back(i * 16'h0100);
        run_burst(0, 100, 16'h0800, q, 11, 1'b0, 0);
        do_reset();
        run_burst(4, 100, 16'h0800, q, 30, 1'b0, 1);
        check("t6_tof", int'(tof), 8);

        // Threshold zero: first SEARCH sample crosses
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(int'($urandom_range(0, 7)) * 16'h0200);
        run_burst(3, 5, 0, q, 20, 1'b0, 1);
        check("thr0_tof", int'(tof), 3);

        // Random bursts, with occasional aborts and resets
        for (int b = 0; b < 60; b++) begin
            int nsamp, nsend;
            q.delete();
            nsamp = int'($urandom_range(0, 40));
            for (int i = 0; i < nsamp; i++) q.push_back(int'($urandom_range(0, 7)) * 16'h0200);
            nsend = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nsamp)) : nsamp;
            run_burst(int'($urandom_range(0, 10)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 7)) * 16'h0200, q, nsend,
                      1'($urandom_range(0, 1)), 2);
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
